// File: rtl/ccsds_pkg.sv
// Shared widths, sigma-case encoding and pipeline payload types for the CCSDS-123 local-sum stage.
package ccsds_pkg;

    localparam int unsigned X_LEN   = 11;
    localparam int unsigned Y_LEN   = 6;
    localparam int unsigned Z_LEN   = 8;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned SIGMA_W = DATA_W + 2;

    typedef enum logic [2:0] {
        LS_NONE,
        LS_W4,
        LS_NNE2,
        LS_FULL,
        LS_LAST
    } ls_case_e;

    // Sample travelling from the address stage to the sigma stage
    typedef struct packed {
        logic [DATA_W-1:0] s;
        logic [X_LEN-1:0]  x;
        logic [Y_LEN-1:0]  y;
        logic [Z_LEN-1:0]  z;
        logic              first;
        logic              frame_last;
        ls_case_e          sel;
    } ls_stage_t;

    typedef struct packed {
        logic [DATA_W-1:0]  s;
        logic [SIGMA_W-1:0] sigma;
        logic [X_LEN-1:0]   x;
        logic [Y_LEN-1:0]   y;
        logic [Z_LEN-1:0]   z;
        logic               first;
        logic               frame_last;
    } ls_out_t;

    // Which neighbours form sigma for a sample at this position
    function automatic ls_case_e ls_sel(input logic y_zero, input logic x_zero, input logic x_last);
        ls_case_e sel;
        if (y_zero && x_zero)  sel = LS_NONE;
        else if (y_zero)       sel = LS_W4;
        else if (x_zero)       sel = LS_NNE2;
        else if (x_last)       sel = LS_LAST;
        else                   sel = LS_FULL;
        return sel;
    endfunction

endpackage

// File: rtl/ccsds_local_sum_if.sv
// Sample-in / annotated-sample-out stream between the receive stage, local-sum stage and predictor.
interface ccsds_local_sum_if;
    import ccsds_pkg::*;

    logic                en_i;
    logic [DATA_W-1:0]   data_i;
    logic                valid_o;
    logic [DATA_W-1:0]   s_o;
    logic [SIGMA_W-1:0]  sigma_o;
    logic [X_LEN-1:0]    x_o;
    logic [Y_LEN-1:0]    y_o;
    logic [Z_LEN-1:0]    z_o;
    logic                first_o;
    logic                frame_last_o;

    modport master (
        output en_i, data_i,
        input  valid_o, s_o, sigma_o, x_o, y_o, z_o, first_o, frame_last_o
    );

    modport slave (
        input  en_i, data_i,
        output valid_o, s_o, sigma_o, x_o, y_o, z_o, first_o, frame_last_o
    );
endinterface

// File: rtl/ccsds_line_ram.sv
// One-row sample store: simple dual-port, one write and one registered read per cycle.
module ccsds_line_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              sclk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // No reset so the array maps onto block RAM
    always_ff @(posedge sclk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/ccsds_local_sum.sv
// Annotates each BIL sample with its wide neighbour-oriented local sum and (x,y,z) position.
module ccsds_local_sum
    import ccsds_pkg::*;
#(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              cfg_en,
    input  logic [X_LEN-1:0]  X_max,
    input  logic [Y_LEN-1:0]  Y_max,
    input  logic [Z_LEN-1:0]  Z_max,
    output logic              cfg_err_o,
    ccsds_local_sum_if.slave  bus
);
    localparam int unsigned LINE_DEPTH = 2 ** ADDR_W;

    logic [X_LEN-1:0]   x_max_q, x_max_d, x_q, x_d;
    logic [Y_LEN-1:0]   y_max_q, y_max_d, y_q, y_d;
    logic [Z_LEN-1:0]   z_max_q, z_max_d, z_q, z_d;
    logic [ADDR_W-1:0]  len_q, len_d, wr_ptr_q, wr_ptr_d, rd_addr_c;
    logic               cfg_err_q, cfg_err_d;
    logic               s1_vld_q, s1_vld_d, valid_q, valid_d;
    ls_stage_t          s1_q, s1_d;
    ls_out_t            out_q, out_d;
    logic [DATA_W-1:0]  w_q, w_d, nw_q, nw_d, n_q, n_d, ne_rd;
    logic [SIGMA_W-1:0] sigma_c;
    logic [31:0]        area_c;
    logic               accept_c, x_last_c, z_last_c, y_last_c;

    assign area_c   = 32'(X_max) * 32'(Z_max);
    assign accept_c = bus.en_i & ~cfg_en;
    assign x_last_c = (x_q == x_max_q - X_LEN'(1));
    assign z_last_c = (z_q == z_max_q - Z_LEN'(1));
    assign y_last_c = (y_q == y_max_q - Y_LEN'(1));
    // NE of the current sample was written one row minus one sample ago
    assign rd_addr_c = wr_ptr_q - len_q + ADDR_W'(1);

    ccsds_line_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_line_ram (
        .sclk    (sclk),
        .wr_en   (accept_c),
        .wr_addr (wr_ptr_q),
        .wr_data (bus.data_i),
        .rd_en   (accept_c),
        .rd_addr (rd_addr_c),
        .rd_data (ne_rd)
    );

    always_comb begin
        sigma_c = '0;
        case (s1_q.sel)
            LS_NONE: sigma_c = '0;
            LS_W4:   sigma_c = SIGMA_W'(w_q) << 2;
            LS_NNE2: sigma_c = (SIGMA_W'(n_q) + SIGMA_W'(ne_rd)) << 1;
            LS_FULL: sigma_c = SIGMA_W'(w_q) + SIGMA_W'(nw_q) + SIGMA_W'(n_q) + SIGMA_W'(ne_rd);
            LS_LAST: sigma_c = SIGMA_W'(w_q) + SIGMA_W'(nw_q) + (SIGMA_W'(n_q) << 1);
            default: sigma_c = '0;
        endcase
    end

    always_comb begin
        x_max_d   = x_max_q;
        y_max_d   = y_max_q;
        z_max_d   = z_max_q;
        len_d     = len_q;
        cfg_err_d = cfg_err_q;
        x_d       = x_q;
        y_d       = y_q;
        z_d       = z_q;
        wr_ptr_d  = wr_ptr_q;
        s1_vld_d  = 1'b0;
        s1_d      = s1_q;
        w_d       = w_q;
        nw_d      = nw_q;
        n_d       = n_q;
        valid_d   = 1'b0;
        out_d     = out_q;

        if (cfg_en) begin
            x_max_d   = X_max;
            y_max_d   = Y_max;
            z_max_d   = Z_max;
            len_d     = ADDR_W'(area_c);
            cfg_err_d = (area_c > LINE_DEPTH) || (X_max < X_LEN'(2));
            x_d       = '0;
            y_d       = '0;
            z_d       = '0;
            wr_ptr_d  = '0;
        end else begin
            if (bus.en_i) begin
                s1_vld_d = 1'b1;
                s1_d     = '{s:          bus.data_i,
                             x:          x_q,
                             y:          y_q,
                             z:          z_q,
                             first:      (x_q == '0) && (y_q == '0),
                             frame_last: x_last_c && z_last_c && y_last_c,
                             sel:        ls_sel(y_q == '0, x_q == '0, x_last_c)};
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                x_d      = x_last_c ? '0 : x_q + X_LEN'(1);
                if (x_last_c) begin
                    z_d = z_last_c ? '0 : z_q + Z_LEN'(1);
                    if (z_last_c) y_d = y_last_c ? '0 : y_q + Y_LEN'(1);
                end
            end
            // Neighbour history shifts only when a sample actually advances
            if (s1_vld_q) begin
                valid_d = 1'b1;
                out_d   = '{s:          s1_q.s,
                            sigma:      sigma_c,
                            x:          s1_q.x,
                            y:          s1_q.y,
                            z:          s1_q.z,
                            first:      s1_q.first,
                            frame_last: s1_q.frame_last};
                n_d     = ne_rd;
                nw_d    = n_q;
                w_d     = s1_q.s;
            end
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            x_max_q   <= '0;
            y_max_q   <= '0;
            z_max_q   <= '0;
            len_q     <= '0;
            cfg_err_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            wr_ptr_q  <= '0;
            s1_vld_q  <= 1'b0;
            s1_q      <= '0;
            w_q       <= '0;
            nw_q      <= '0;
            n_q       <= '0;
            valid_q   <= 1'b0;
            out_q     <= '0;
        end else begin
            x_max_q   <= x_max_d;
            y_max_q   <= y_max_d;
            z_max_q   <= z_max_d;
            len_q     <= len_d;
            cfg_err_q <= cfg_err_d;
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            wr_ptr_q  <= wr_ptr_d;
            s1_vld_q  <= s1_vld_d;
            s1_q      <= s1_d;
            w_q       <= w_d;
            nw_q      <= nw_d;
            n_q       <= n_d;
            valid_q   <= valid_d;
            out_q     <= out_d;
        end
    end

    assign cfg_err_o        = cfg_err_q;
    assign bus.valid_o      = valid_q;
    assign bus.s_o          = out_q.s;
    assign bus.sigma_o      = out_q.sigma;
    assign bus.x_o          = out_q.x;
    assign bus.y_o          = out_q.y;
    assign bus.z_o          = out_q.z;
    assign bus.first_o      = out_q.first;
    assign bus.frame_last_o = out_q.frame_last;
endmodule

// File: tb/tb_ccsds_local_sum.sv
// Directed bench for ccsds_local_sum: positional reference model plus hand-computed sigma tables.
module tb_ccsds_local_sum;
    import ccsds_pkg::*;

    logic             sclk = 1'b0;
    logic             rst_n;
    logic             cfg_en;
    logic [X_LEN-1:0] X_max;
    logic [Y_LEN-1:0] Y_max;
    logic [Z_LEN-1:0] Z_max;
    logic             cfg_err_o;

    ccsds_local_sum_if bus();

    ccsds_local_sum dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .cfg_en    (cfg_en),
        .X_max     (X_max),
        .Y_max     (Y_max),
        .Z_max     (Z_max),
        .cfg_err_o (cfg_err_o),
        .bus       (bus)
    );

    always #5 sclk = ~sclk;

    typedef struct {
        logic [DATA_W-1:0]  s;
        logic [SIGMA_W-1:0] sigma;
        logic [X_LEN-1:0]   x;
        logic [Y_LEN-1:0]   y;
        logic [Z_LEN-1:0]   z;
        logic               first;
        logic               last;
        logic               skip;
    } exp_t;

    exp_t               exp_q[$];
    int                 checks;
    int                 errors;
    logic               h0, h1;
    int                 mx, my, mz, mlen, px, py, pz;
    logic               merr;
    logic [15:0]        fr_mem [65536];
    logic [SIGMA_W-1:0] obs_sigma [64];
    logic               obs_first [64];
    logic               obs_last [64];
    int                 n_out;

    logic [SIGMA_W-1:0] t1_sig [12] = '{0, 4, 8, 12, 6, 11, 15, 18, 22, 27, 31, 34};
    logic [15:0]        t2_dat [12] = '{1, 2, 3, 100, 200, 300, 4, 5, 6, 7, 8, 9};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        chk("valid_o", 64'(bus.valid_o), 64'(h1));
        if (h1) begin
            e = exp_q.pop_front();
            chk("s_o", 64'(bus.s_o), 64'(e.s));
            chk("x_o", 64'(bus.x_o), 64'(e.x));
            chk("y_o", 64'(bus.y_o), 64'(e.y));
            chk("z_o", 64'(bus.z_o), 64'(e.z));
            chk("first_o", 64'(bus.first_o), 64'(e.first));
            chk("frame_last_o", 64'(bus.frame_last_o), 64'(e.last));
            if (!e.skip) chk("sigma_o", 64'(bus.sigma_o), 64'(e.sigma));
            if (n_out < 64) begin
                obs_sigma[n_out] = bus.sigma_o;
                obs_first[n_out] = bus.first_o;
                obs_last[n_out]  = bus.frame_last_o;
            end
            n_out++;
        end
    endtask

    // Positional reference: neighbours looked up by (x,y,z) in a frame image
    task automatic model_push(input logic [15:0] d);
        exp_t e;
        int idx;
        logic [SIGMA_W-1:0] w, nw, n, ne;
        idx = py * mlen + pz * mx + px;
        fr_mem[16'(idx)] = d;
        e.s     = d;
        e.x     = X_LEN'(px);
        e.y     = Y_LEN'(py);
        e.z     = Z_LEN'(pz);
        e.first = (px == 0) && (py == 0);
        e.last  = (px == mx - 1) && (pz == mz - 1) && (py == my - 1);
        e.skip  = merr && (py != 0);
        e.sigma = '0;
        if (py == 0) begin
            if (px != 0) begin
                w = SIGMA_W'(fr_mem[16'(idx - 1)]);
                e.sigma = w << 2;
            end
        end else if (!e.skip) begin
            n  = SIGMA_W'(fr_mem[16'(idx - mlen)]);
            ne = SIGMA_W'(fr_mem[16'(idx - mlen + 1)]);
            if (px == 0) begin
                e.sigma = (n + ne) << 1;
            end else begin
                w  = SIGMA_W'(fr_mem[16'(idx - 1)]);
                nw = SIGMA_W'(fr_mem[16'(idx - mlen - 1)]);
                if (px == mx - 1) e.sigma = w + nw + (n << 1);
                else              e.sigma = w + nw + n + ne;
            end
        end
        exp_q.push_back(e);
        if (px == mx - 1) begin
            px = 0;
            if (pz == mz - 1) begin
                pz = 0;
                py = (py == my - 1) ? 0 : py + 1;
            end else begin
                pz++;
            end
        end else begin
            px++;
        end
    endtask

    task automatic cycle(input logic en, input logic [15:0] d);
        @(negedge sclk);
        check_out();
        h1 = h0;
        h0 = en;
        cfg_en = 1'b0;
        bus.en_i = en;
        bus.data_i = d;
        if (en) model_push(d);
    endtask

    task automatic do_cfg(input int x, input int y, input int z);
        @(negedge sclk);
        check_out();
        cfg_en = 1'b1;
        X_max = X_LEN'(x);
        Y_max = Y_LEN'(y);
        Z_max = Z_LEN'(z);
        bus.en_i = 1'b0;
        h0 = 1'b0;
        h1 = 1'b0;
        exp_q.delete();
        mx = x; my = y; mz = z; mlen = x * z;
        merr = (x * z > 16384) || (x < 2);
        px = 0; py = 0; pz = 0;
        n_out = 0;
        cycle(1'b0, 16'h0);
        chk("cfg_err_o", 64'(cfg_err_o), 64'(merr));
    endtask

    task automatic drain();
        repeat (3) cycle(1'b0, 16'h0);
    endtask

    initial begin
        checks = 0; errors = 0; h0 = 1'b0; h1 = 1'b0; n_out = 0;
        mx = 2; my = 1; mz = 1; mlen = 2; px = 0; py = 0; pz = 0; merr = 1'b0;
        rst_n = 1'b0; cfg_en = 1'b0; X_max = '0; Y_max = '0; Z_max = '0;
        bus.en_i = 1'b0; bus.data_i = '0;
        repeat (3) @(negedge sclk);
        rst_n = 1'b1;
        @(negedge sclk);
        chk("rst_valid_o", 64'(bus.valid_o), 64'd0);
        chk("rst_s_o", 64'(bus.s_o), 64'd0);
        chk("rst_sigma_o", 64'(bus.sigma_o), 64'd0);
        chk("rst_x_o", 64'(bus.x_o), 64'd0);
        chk("rst_y_o", 64'(bus.y_o), 64'd0);
        chk("rst_z_o", 64'(bus.z_o), 64'd0);
        chk("rst_first_o", 64'(bus.first_o), 64'd0);
        chk("rst_frame_last_o", 64'(bus.frame_last_o), 64'd0);
        chk("rst_cfg_err_o", 64'(cfg_err_o), 64'd0);

        // 4x1 bands, 3 rows, continuous 1..12
        do_cfg(4, 3, 1);
        for (int i = 1; i <= 12; i++) cycle(1'b1, 16'(i));
        drain();
        for (int i = 0; i < 12; i++) chk("t1_sigma", 64'(obs_sigma[i]), 64'(t1_sig[i]));
        chk("t1_first0", 64'(obs_first[0]), 64'd1);
        chk("t1_first1", 64'(obs_first[1]), 64'd0);
        chk("t1_last11", 64'(obs_last[11]), 64'd1);

        // Two bands: north neighbours must come from the same band
        do_cfg(3, 2, 2);
        for (int i = 0; i < 12; i++) cycle(1'b1, t2_dat[i]);
        drain();
        chk("t2_sigma_b0", 64'(obs_sigma[6]), 64'd6);
        chk("t2_sigma_b1", 64'(obs_sigma[9]), 64'd600);
        chk("t2_sigma_w4", 64'(obs_sigma[4]), 64'd400);

        // Sparse strobe; dimension inputs change without cfg_en
        do_cfg(4, 3, 1);
        X_max = 11'd7;
        Z_max = 8'd3;
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, 16'(i));
            cycle(1'b0, 16'hdead);
            cycle(1'b0, 16'hbeef);
        end
        drain();
        for (int i = 0; i < 12; i++) chk("t3_sigma", 64'(obs_sigma[i]), 64'(t1_sig[i]));

        // Full-scale samples and frame wrap
        do_cfg(2, 2, 2);
        for (int i = 0; i < 9; i++) cycle(1'b1, 16'hffff);
        drain();
        chk("t5_sigma_max", 64'(obs_sigma[4]), 64'd262140);
        chk("t5_sigma_last", 64'(obs_sigma[7]), 64'd262140);
        chk("t5_frame_last", 64'(obs_last[7]), 64'd1);
        chk("t5_wrap_first", 64'(obs_first[8]), 64'd1);
        chk("t5_wrap_sigma", 64'(obs_sigma[8]), 64'd0);

        // Restart mid-frame
        do_cfg(4, 3, 1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 16'(i + 20));
        do_cfg(4, 3, 1);
        cycle(1'b1, 16'd50);
        cycle(1'b1, 16'd60);
        drain();
        chk("t6_restart_first", 64'(obs_first[0]), 64'd1);
        chk("t6_restart_sigma", 64'(obs_sigma[1]), 64'd200);

        // Asynchronous reset with samples in flight
        cycle(1'b1, 16'd1);
        cycle(1'b1, 16'd2);
        cycle(1'b1, 16'd3);
        @(negedge sclk);
        rst_n = 1'b0;
        bus.en_i = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(bus.valid_o), 64'd0);
        h0 = 1'b0;
        h1 = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge sclk);
        rst_n = 1'b1;
        @(negedge sclk);
        chk("t6_rst_valid_after", 64'(bus.valid_o), 64'd0);
        do_cfg(4, 3, 1);
        for (int i = 1; i <= 5; i++) cycle(1'b1, 16'(i * 3));
        drain();

        // Row exactly fills the line RAM
        do_cfg(128, 2, 128);
        for (int i = 0; i < 32770; i++) cycle(1'b1, 16'($urandom));
        drain();

        // Configuration errors are sticky until the next cfg_en
        do_cfg(145, 1, 113);
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'(i + 7));
        drain();
        chk("t4_err_sticky", 64'(cfg_err_o), 64'd1);
        do_cfg(1, 2, 2);
        for (int i = 0; i < 4; i++) cycle(1'b1, 16'(i + 9));
        drain();
        chk("t4_err_x1_sticky", 64'(cfg_err_o), 64'd1);
        do_cfg(4, 3, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
